// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI bus arbiter.
// Holds the FSM state encoding, the op-type encoding and the default WAIT bound.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain
    } arb_state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/spi_arb_rr2.sv
// Combinational two-way round-robin pick: on a tie the requester that did not win
// last time is chosen. Returns a one-hot grant, zero when nothing is pending.
module spi_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_granted,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = last_granted ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two requesters share one SPI bus port, one transaction at a time, round-robin.
// Define SPI_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES with req_err.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_read,
    input  logic [1:0]        req_write,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [DATA_W-1:0] req_rdata,
    output logic [1:0]        req_ack,
    output logic [1:0]        req_err,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_read_response,
    input  logic              m_write_response,
    output logic [1:0]        grant,
    output logic              busy
);

    arb_state_e state;
    logic       last_granted;
    logic       op;
    logic [1:0] pending;
    logic [1:0] pick;
    logic       win_idx;
    logic       resp_match;
    logic       timeout_hit;

    assign pending    = req_read | req_write;
    assign win_idx    = pick[1];
    // Only the response matching the op in flight may complete it.
    assign resp_match = (op == OP_READ) ? m_read_response : m_write_response;
    assign busy       = (state != StIdle);

    spi_arb_rr2 u_rr2 (
        .req          (pending),
        .last_granted (last_granted),
        .grant        (pick)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       err_q;

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign req_err     = err_q;
`else
    assign timeout_hit = 1'b0;
    assign req_err     = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            last_granted <= 1'b1;
            op           <= OP_READ;
            grant        <= 2'b00;
            req_ack      <= 2'b00;
            req_rdata    <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_wdata      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            err_q        <= 2'b00;
`endif
        end else begin
            req_ack   <= 2'b00;
            req_rdata <= '0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q     <= 2'b00;
`endif
            case (state)
                StIdle: begin
                    if (|pending) begin
                        // Read beats write for the same requester; the write stays pending.
                        last_granted <= win_idx;
                        grant        <= pick;
                        op           <= req_read[win_idx] ? OP_READ : OP_WRITE;
                        m_read       <= req_read[win_idx];
                        m_write      <= ~req_read[win_idx];
                        m_wdata      <= win_idx ? req_wdata1 : req_wdata0;
                        state        <= StIssue;
                    end
                end
                StIssue: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= StWait;
                end
                StWait: begin
                    if (resp_match) begin
                        req_ack <= grant;
                        if (op == OP_READ) begin
                            req_rdata <= m_rdata;
                        end
                        state <= StDrain;
                    end else if (timeout_hit) begin
                        req_ack <= grant;
`ifdef SPI_ARB_TIMEOUT_EN
                        err_q   <= grant;
`endif
                        state   <= StDrain;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                StDrain: begin
                    // The port holds its response for two cycles; let it fall first.
                    if (!(m_read_response || m_write_response)) begin
                        grant <= 2'b00;
                        state <= StIdle;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
